// File: rtl/adc_range_pkg.sv
// -----------------------------------------------------------------------------
// adc_range_pkg
// Shared types for the ADC sample-clock range controller.
//   range_t   : clock-mux select encodings (MID=0, HIGH=1, LOW=2; 3 unused)
//   state_t   : controller sequencing states
//   cnt_width : bit width needed to hold a count of 0..max_val
// -----------------------------------------------------------------------------
package adc_range_pkg;

  typedef enum logic [1:0] {
    RNG_MID  = 2'd0,
    RNG_HIGH = 2'd1,
    RNG_LOW  = 2'd2
  } range_t;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    SWITCH,
    SETTLE
  } state_t;

  // Width of a down/up counter that must represent 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_range_classifier.sv
// -----------------------------------------------------------------------------
// adc_range_classifier
// Purely combinational hysteresis classifier. Given the current mux select
// and a frequency measurement, returns the range the measurement belongs to.
// Leaving a range requires crossing its boundary by the hysteresis margin.
//
// Ports:
//   fx_data   in  FX_W  measured frequency (unsigned)
//   sel       in  2     current mux select (range_t encoding)
//   candidate out 2     range the measurement indicates
// -----------------------------------------------------------------------------
module adc_range_classifier
  import adc_range_pkg::*;
#(
  parameter int unsigned     FX_W    = 64,
  parameter longint unsigned LO_TH   = 100,
  parameter longint unsigned HI_TH   = 100000,
  parameter longint unsigned LO_HYST = 5,
  parameter longint unsigned HI_HYST = 1000
) (
  input  logic [FX_W-1:0] fx_data,
  input  logic [1:0]      sel,
  output range_t          candidate
);

  // One extra bit so TH+HYST can never wrap at the measurement width.
  typedef logic [FX_W:0] wide_t;

  localparam wide_t LO_TH_W   = wide_t'(LO_TH);
  localparam wide_t HI_TH_W   = wide_t'(HI_TH);
  localparam wide_t LO_HYST_W = wide_t'(LO_HYST);
  localparam wide_t HI_HYST_W = wide_t'(HI_HYST);

  localparam wide_t LO_UP = LO_TH_W + LO_HYST_W;
  localparam wide_t HI_UP = HI_TH_W + HI_HYST_W;
  // Lower edges clamp at zero rather than wrapping to a huge threshold.
  localparam wide_t LO_DN = (LO_HYST_W > LO_TH_W) ? '0 : LO_TH_W - LO_HYST_W;
  localparam wide_t HI_DN = (HI_HYST_W > HI_TH_W) ? '0 : HI_TH_W - HI_HYST_W;

  wide_t fx_w;
  assign fx_w = {1'b0, fx_data};

  // NOTE: every output of an always_comb is given a value before any branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    candidate = RNG_MID;
    unique case (sel)
      2'd0: begin
        if (fx_w >= HI_UP)      candidate = RNG_HIGH;
        else if (fx_w < LO_DN)  candidate = RNG_LOW;
        else                    candidate = RNG_MID;
      end
      2'd1: begin
        if (fx_w < HI_DN)       candidate = (fx_w < LO_DN) ? RNG_LOW : RNG_MID;
        else                    candidate = RNG_HIGH;
      end
      2'd2: begin
        if (fx_w >= LO_UP)      candidate = (fx_w >= HI_UP) ? RNG_HIGH : RNG_MID;
        else                    candidate = RNG_LOW;
      end
      default:                  candidate = RNG_MID;
    endcase
  end

endmodule

// File: rtl/adc_clk_range_ctrl.sv
// -----------------------------------------------------------------------------
// adc_clk_range_ctrl
// Selects one of three ADC sample clocks from frequency measurements. A range
// change needs CONFIRM consecutive agreeing samples, then runs a gated switch:
// clock enable low (GATE_CYC cycles), select change (SWITCH), settle
// (SETTLE_CYC cycles), enable high. The select only moves while the enable
// is low, which is what keeps the downstream clock mux glitch-free.
//
// Optional build macro FORCE_RANGE_EN adds a manual range override
// (force_en / force_sel) that bypasses confirmation.
//
// Ports:
//   clk          in   1     control clock
//   rst          in   1     asynchronous active-low reset
//   fx_data      in   FX_W  measured frequency
//   fx_valid     in   1     one-cycle strobe qualifying fx_data
//   force_en     in   1     (FORCE_RANGE_EN) request manual range
//   force_sel    in   2     (FORCE_RANGE_EN) requested range, 3 ignored
//   sel          out  2     mux select: 0=mid, 1=high, 2=low
//   clk_en       out  1     ADC clock gate enable
//   busy         out  1     high whenever not in IDLE
//   switch_done  out  1     one-cycle pulse in the first IDLE after a switch
// -----------------------------------------------------------------------------
module adc_clk_range_ctrl
  import adc_range_pkg::*;
#(
  parameter int unsigned     FX_W       = 64,
  parameter longint unsigned LO_TH      = 100,
  parameter longint unsigned HI_TH      = 100000,
  parameter longint unsigned LO_HYST    = 5,
  parameter longint unsigned HI_HYST    = 1000,
  parameter int unsigned     CONFIRM    = 3,
  parameter int unsigned     GATE_CYC   = 4,
  parameter int unsigned     SETTLE_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [FX_W-1:0] fx_data,
  input  logic            fx_valid,
`ifdef FORCE_RANGE_EN
  input  logic            force_en,
  input  logic [1:0]      force_sel,
`endif
  output logic [1:0]      sel,
  output logic            clk_en,
  output logic            busy,
  output logic            switch_done
);

  localparam int unsigned CNT_W = cnt_width(CONFIRM);
  localparam int unsigned TMR_W =
    cnt_width((GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC);

  localparam logic [CNT_W-1:0] CONFIRM_V   = CNT_W'(CONFIRM);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

  state_t           state_q,   state_d;
  logic [TMR_W-1:0] timer_q,   timer_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  range_t           pending_q, pending_d;
  range_t           target_q,  target_d;
  range_t           sel_q,     sel_d;
  logic             from_sw_q, from_sw_d;  // SETTLE was entered from SWITCH
  logic             done_q,    done_d;
  range_t           candidate;

  logic             force_req;   // override active: automatic control paused
  logic             force_go;    // override asks for a real range change
  range_t           force_tgt;

`ifdef FORCE_RANGE_EN
  assign force_req = force_en;
  assign force_go  = force_en && (force_sel != sel_q) && (force_sel != 2'd3);
  assign force_tgt = range_t'(force_sel);
`else
  assign force_req = 1'b0;
  assign force_go  = 1'b0;
  assign force_tgt = RNG_MID;
`endif

  adc_range_classifier #(
    .FX_W    (FX_W),
    .LO_TH   (LO_TH),
    .HI_TH   (HI_TH),
    .LO_HYST (LO_HYST),
    .HI_HYST (HI_HYST)
  ) u_classifier (
    .fx_data   (fx_data),
    .sel       (sel_q),
    .candidate (candidate)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = '0;          // confirmation only accumulates in IDLE
    cnt_inc   = '0;
    pending_d = pending_q;
    target_d  = target_q;
    sel_d     = sel_q;
    from_sw_d = from_sw_q;
    done_d    = 1'b0;
    clk_en    = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      IDLE: begin
        clk_en = 1'b1;
        busy   = 1'b0;
        cnt_d  = cnt_q;
        if (force_req) begin
          cnt_d = '0;
          if (force_go) begin
            state_d  = GATE;
            timer_d  = GATE_LOAD;
            target_d = force_tgt;
          end
        end else if (fx_valid) begin
          if (candidate == sel_q) begin
            cnt_d = '0;
          end else begin
            // A different disagreeing range restarts the run at one sample.
            cnt_inc   = (candidate == pending_q) ? cnt_q + 1'b1 : CNT_W'(1);
            pending_d = candidate;
            if (cnt_inc == CONFIRM_V) begin
              state_d  = GATE;
              timer_d  = GATE_LOAD;
              target_d = candidate;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
      end

      GATE: begin
        if (timer_q == '0) begin
          // Select moves on entry to SWITCH, while the enable is still low.
          state_d = SWITCH;
          sel_d   = target_q;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      SWITCH: begin
        state_d   = SETTLE;
        timer_d   = SETTLE_LOAD;
        from_sw_d = 1'b1;
      end

      SETTLE: begin
        if (timer_q == '0) begin
          state_d   = IDLE;
          done_d    = from_sw_q;   // post-reset settle exits silently
          from_sw_d = 1'b0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SETTLE;
      timer_q   <= SETTLE_LOAD;
      cnt_q     <= '0;
      pending_q <= RNG_MID;
      target_q  <= RNG_MID;
      sel_q     <= RNG_MID;
      from_sw_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      sel_q     <= sel_d;
      from_sw_q <= from_sw_d;
      done_q    <= done_d;
    end
  end

  assign sel         = sel_q;
  assign switch_done = done_q;

endmodule
